// File: rtl/mem_bus_ctrl.sv
// Bus controller between the processor memory port and the MMU, with wait-state
// timing and a small I/O window holding a switch register and an output port.
module mem_bus_ctrl #(
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_BASE     = 32'h0000_FFF0
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic [31:0] iAddr,
    input  logic [31:0] iData,
    input  logic        iRead,
    input  logic        iWrite,
    output logic [31:0] oData,
    output logic        oRdy,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemData,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic [31:0] iMemData,
    input  logic [17:0] iSW,
    output logic [31:0] oPORT,
    output logic [1:0]  oDbgState
);

    // Handshake: a request is accepted only when iRead or iWrite is high in IDLE;
    // completion is signalled by a single-cycle oRdy, and oData is valid only then.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        is_write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] port_q;
    logic [17:0] sw_meta_q;
    logic [17:0] sw_sync_q;

    logic        req;
    logic        req_io;
    logic [31:0] io_off;
    logic        io_mapped;
    logic [1:0]  io_sel;
    logic [31:0] io_rdata;
    logic        port_wr;

    assign req       = iRead | iWrite;
    assign req_io    = (iAddr >= IO_BASE);
    assign io_off    = iAddr - IO_BASE;
    assign io_mapped = (io_off < 32'h0000_0010);
    assign io_sel    = iAddr[3:2];
    assign port_wr   = (state_q == IDLE) && req && req_io && iWrite
                       && io_mapped && (io_sel == 2'd1);

    always_comb begin
        io_rdata = 32'h0;
        if (io_mapped) begin
            case (io_sel)
                2'd0:    io_rdata = {14'h0, sw_sync_q};
                2'd1:    io_rdata = port_q;
                default: io_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        oRdy      = 1'b0;
        oMemRead  = 1'b0;
        oMemWrite = 1'b0;
        oData     = 32'h0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = req_io ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                oMemRead  = ~is_write_q;
                oMemWrite = is_write_q;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                oRdy    = 1'b1;
                oData   = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            port_q     <= 32'h0;
            sw_meta_q  <= 18'h0;
            sw_sync_q  <= 18'h0;
        end else begin
            sw_meta_q <= iSW;
            sw_sync_q <= sw_meta_q;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q     <= iAddr;
                        wdata_q    <= iData;
                        is_write_q <= iWrite;
                        if (req_io) begin
                            // I/O completes at this edge; writes return zero data.
                            rdata_q <= iWrite ? 32'h0 : io_rdata;
                            if (port_wr) begin
                                port_q <= iData;
                            end
                        end else begin
                            cnt_q   <= WAIT_CNT;
                            rdata_q <= 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!is_write_q) begin
                        rdata_q <= iMemData;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oMemAddr  = addr_q;
    assign oMemData  = wdata_q;
    assign oPORT     = port_q;
    assign oDbgState = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one instance with 1 wait state, one with 3,
// expected read data queued per transaction and checked when oRdy appears.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRst;
    logic [17:0] sw;
    logic [31:0] addr_s[2];
    logic [31:0] wdat_s[2];
    logic [31:0] odat_s[2];
    logic [31:0] maddr_s[2];
    logic [31:0] mdat_s[2];
    logic [31:0] imem_s[2];
    logic [31:0] port_s[2];
    logic        rd_s[2];
    logic        wr_s[2];
    logic        rdy_s[2];
    logic        mrd_s[2];
    logic        mwr_s[2];
    logic [1:0]  st_s[2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    logic [31:0] e_a, e_b;

    mem_bus_ctrl #(.WAIT_STATES(1)) u_dut_a (
        .iClk(clk), .nRst(nRst), .iAddr(addr_s[0]), .iData(wdat_s[0]),
        .iRead(rd_s[0]), .iWrite(wr_s[0]), .oData(odat_s[0]), .oRdy(rdy_s[0]),
        .oMemAddr(maddr_s[0]), .oMemData(mdat_s[0]), .oMemRead(mrd_s[0]),
        .oMemWrite(mwr_s[0]), .iMemData(imem_s[0]), .iSW(sw), .oPORT(port_s[0]),
        .oDbgState(st_s[0])
    );

    mem_bus_ctrl #(.WAIT_STATES(3)) u_dut_b (
        .iClk(clk), .nRst(nRst), .iAddr(addr_s[1]), .iData(wdat_s[1]),
        .iRead(rd_s[1]), .iWrite(wr_s[1]), .oData(odat_s[1]), .oRdy(rdy_s[1]),
        .oMemAddr(maddr_s[1]), .oMemData(mdat_s[1]), .oMemRead(mrd_s[1]),
        .oMemWrite(mwr_s[1]), .iMemData(imem_s[1]), .iSW(sw), .oPORT(port_s[1]),
        .oDbgState(st_s[1])
    );

    // Synchronous MMU model: fixed word at 0x100, otherwise address XOR pattern.
    function automatic logic [31:0] mmu_model(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h1234_5678 : (a ^ 32'h5A5A_0000);
    endfunction

    always_ff @(posedge clk) begin
        imem_s[0] <= mmu_model(maddr_s[0]);
        imem_s[1] <= mmu_model(maddr_s[1]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nRst === 1'b1 && rdy_s[0] === 1'b1) begin
            n_checks++;
            if (exp_q_a.size() == 0) begin
                n_fail++;
                $display("FAIL stray_rdy_a: oRdy high with nothing pending, oData %h", odat_s[0]);
            end else begin
                e_a = exp_q_a.pop_front();
                if (odat_s[0] !== e_a) begin
                    n_fail++;
                    $display("FAIL odata_a: got %h expected %h", odat_s[0], e_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (nRst === 1'b1 && rdy_s[1] === 1'b1) begin
            n_checks++;
            if (exp_q_b.size() == 0) begin
                n_fail++;
                $display("FAIL stray_rdy_b: oRdy high with nothing pending, oData %h", odat_s[1]);
            end else begin
                e_b = exp_q_b.pop_front();
                if (odat_s[1] !== e_b) begin
                    n_fail++;
                    $display("FAIL odata_b: got %h expected %h", odat_s[1], e_b);
                end
            end
        end
    end

    task automatic push_exp(input int s, input logic [31:0] v);
        if (s == 0) exp_q_a.push_back(v);
        else        exp_q_b.push_back(v);
    endtask

    // One transaction: oRdy expected in cycle lat; RAM strobes in cycles 1..lat-1.
    task automatic txn(input int s, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input int lat, input logic ram);
        @(posedge clk); #1;
        rd_s[s] = rd; wr_s[s] = wr; addr_s[s] = a; wdat_s[s] = d;
        push_exp(s, exp_d);
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rd_s[s] = 1'b0;
                wr_s[s] = 1'b0;
            end
            chk($sformatf("rdy_%0d_a%h_c%0d", s, a, k), {31'h0, rdy_s[s]}, {31'h0, k == lat});
            if (ram && k < lat) begin
                chk($sformatf("mrd_%0d_a%h_c%0d", s, a, k), {31'h0, mrd_s[s]}, {31'h0, rd & ~wr});
                chk($sformatf("mwr_%0d_a%h_c%0d", s, a, k), {31'h0, mwr_s[s]}, {31'h0, wr});
                chk($sformatf("maddr_%0d_c%0d", s, k), maddr_s[s], a);
                chk($sformatf("mdat_%0d_c%0d", s, k), mdat_s[s], d);
            end else if (k == lat) begin
                chk($sformatf("strobes_off_%0d_a%h", s, a), {30'h0, mrd_s[s], mwr_s[s]}, 32'h0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0;
        sw   = 18'h0;
        for (int i = 0; i < 2; i++) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 32'h0; wdat_s[i] = 32'h0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_rdy_%0d", i), {31'h0, rdy_s[i]}, 32'h0);
            chk($sformatf("rst_strobes_%0d", i), {30'h0, mrd_s[i], mwr_s[i]}, 32'h0);
            chk($sformatf("rst_odata_%0d", i), odat_s[i], 32'h0);
            chk($sformatf("rst_maddr_%0d", i), maddr_s[i], 32'h0);
            chk($sformatf("rst_mdata_%0d", i), mdat_s[i], 32'h0);
            chk($sformatf("rst_port_%0d", i), port_s[i], 32'h0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) nRst = 1'b1;

        // RAM write and read at both wait-state settings
        txn(0, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3, 1'b1);
        txn(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 5, 1'b1);
        txn(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 3, 1'b1);

        // Output port write, visible in cycle 1, then read back
        txn(0, 1'b0, 1'b1, 32'h0000_FFF4, 32'h0000_00A5, 32'h0, 1, 1'b0);
        chk("port_after_write", port_s[0], 32'h0000_00A5);
        txn(0, 1'b1, 1'b0, 32'h0000_FFF4, 32'h0, 32'h0000_00A5, 1, 1'b0);

        // Switch register through the synchroniser; writes to it are ignored
        sw = 18'h2ABCD;
        repeat (2) @(posedge clk);
        txn(0, 1'b1, 1'b0, 32'h0000_FFF0, 32'h0, 32'h0002_ABCD, 1, 1'b0);
        txn(0, 1'b0, 1'b1, 32'h0000_FFF0, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h0000_FFF3, 32'h0, 32'h0002_ABCD, 1, 1'b0);
        chk("port_after_sw_write", port_s[0], 32'h0000_00A5);

        // Unmapped I/O, including an address past the 16-byte register block
        txn(0, 1'b1, 1'b0, 32'h0000_FFF8, 32'h0, 32'h0, 1, 1'b0);
        txn(0, 1'b0, 1'b1, 32'h0000_FFFC, 32'h0000_0011, 32'h0, 1, 1'b0);
        txn(0, 1'b0, 1'b1, 32'h0001_0004, 32'h0000_0077, 32'h0, 1, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h0001_0004, 32'h0, 32'h0, 1, 1'b0);
        chk("port_after_unmapped", port_s[0], 32'h0000_00A5);

        // Last byte below the window is RAM
        txn(1, 1'b1, 1'b0, 32'h0000_FFEF, 32'h0, 32'h5A5A_FFEF, 5, 1'b1);

        // Read and write together is a write
        txn(0, 1'b1, 1'b1, 32'h0000_0240, 32'hCAFE_F00D, 32'h0, 3, 1'b1);

        // Request held after oRdy starts a second transaction
        @(posedge clk); #1;
        rd_s[0] = 1'b1; addr_s[0] = 32'h0000_0200;
        push_exp(0, 32'h5A5A_0200);
        push_exp(0, 32'h5A5A_0200);
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("hold_rdy_c%0d", k), {31'h0, rdy_s[0]}, {31'h0, k == 3 || k == 7});
            chk($sformatf("hold_mrd_c%0d", k), {31'h0, mrd_s[0]},
                {31'h0, k == 1 || k == 2 || k == 5 || k == 6});
            if (k == 5) rd_s[0] = 1'b0;
        end

        // Request pulsed during ACCESS is ignored
        @(posedge clk); #1;
        rd_s[1] = 1'b1; addr_s[1] = 32'h0000_0300;
        push_exp(1, 32'h5A5A_0300);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) rd_s[1] = 1'b0;
            if (k == 2) begin
                wr_s[1] = 1'b1; addr_s[1] = 32'h0000_FFF4; wdat_s[1] = 32'h0000_0055;
            end
            if (k == 3) wr_s[1] = 1'b0;
            chk($sformatf("pulse_rdy_c%0d", k), {31'h0, rdy_s[1]}, {31'h0, k == 5});
            if (k < 5) begin
                chk($sformatf("pulse_maddr_c%0d", k), maddr_s[1], 32'h0000_0300);
                chk($sformatf("pulse_strobes_c%0d", k), {30'h0, mrd_s[1], mwr_s[1]}, 32'h2);
            end
        end
        repeat (4) @(negedge clk);
        chk("pulse_port_unchanged", port_s[1], 32'h0);

        // Asynchronous reset in the middle of a RAM write
        @(posedge clk); #1;
        wr_s[0] = 1'b1; addr_s[0] = 32'h0000_0180; wdat_s[0] = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        wr_s[0] = 1'b0;
        chk("pre_reset_mwr", {31'h0, mwr_s[0]}, 32'h1);
        #2 nRst = 1'b0;
        #1;
        chk("reset_mwr", {31'h0, mwr_s[0]}, 32'h0);
        chk("reset_rdy", {31'h0, rdy_s[0]}, 32'h0);
        chk("reset_port", port_s[0], 32'h0);
        chk("reset_maddr", maddr_s[0], 32'h0);
        chk("reset_mdata", mdat_s[0], 32'h0);
        chk("reset_state", {30'h0, st_s[0]}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) nRst = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_state", {30'h0, st_s[0]}, 32'h0);

        // Normal operation resumes; switch synchroniser was cleared by reset then refilled
        txn(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 3, 1'b1);
        txn(0, 1'b1, 1'b0, 32'h0000_FFF0, 32'h0, 32'h0002_ABCD, 1, 1'b0);
        repeat (3) @(negedge clk);

        chk("exp_q_a_drained", exp_q_a.size(), 32'h0);
        chk("exp_q_b_drained", exp_q_b.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Bus controller between the processor's memory port and the MMU. It turns single-cycle processor read/write requests into timed MMU accesses with a configurable wait-state count, and returns a one-cycle ready pulse that drives the processor's `iMemRdy`. It also decodes a small memory-mapped I/O window that holds a synchronised switch input register and a writable output port register. The output port register feeds the seven-segment display.

## Interface
Parameters:
- `WAIT_STATES`, 1: extra ACCESS cycles beyond the first; legal range 1..15. The minimum is 1 because the MMU read is synchronous.
- `IO_BASE`, 32'h0000_FFF0: first byte address of the I/O window; the window covers `IO_BASE` to 32'hFFFF_FFFF.

Ports:
- `iClk` in 1: system clock; every register updates on its rising edge.
- `nRst` in 1: asynchronous, active-low reset.
- `iAddr` in 32: processor byte address.
- `iData` in 32: processor write data.
- `iRead` in 1: processor read request.
- `iWrite` in 1: processor write request.
- `oData` out 32: read data to the processor; valid while `oRdy` is high.
- `oRdy` out 1: one-cycle completion pulse to the processor.
- `oMemAddr` out 32: MMU address, registered.
- `oMemData` out 32: MMU write data, registered.
- `oMemRead` out 1: MMU read strobe.
- `oMemWrite` out 1: MMU write strobe.
- `iMemData` in 32: MMU read data.
- `iSW` in 18: raw switch inputs.
- `oPORT` out 32: output port register.

## Operation
- States:
  - IDLE: waits for a request.
  - ACCESS: MMU strobe active, wait counter running.
  - DONE: drives the `oRdy` pulse.
- IDLE:
  - Acts when `iRead` or `iWrite` is high.
  - Latches `iAddr`, `iData` and the operation. If `iRead` and `iWrite` are both high, the request is a write.
  - If `iAddr` < `IO_BASE`, the request is a RAM access: load counter with `WAIT_STATES` and go to ACCESS.
  - Otherwise it is an I/O access, completed at this edge: go to DONE.
- ACCESS:
  - Exactly one of `oMemRead`/`oMemWrite` is high, matching the latched operation.
  - `oMemAddr` and `oMemData` hold the latched values.
  - Each cycle with counter ≠ 0: decrement.
  - Cycle with counter = 0: capture `iMemData` into the read-data register (reads only) and go to DONE.
- DONE:
  - `oRdy` = 1 and `oData` = read-data register. For writes, `oData` = 0.
  - Strobes are low.
  - Next state is IDLE unconditionally.
- The requester must drop `iRead`/`iWrite` in the cycle after `oRdy`. A request still high in IDLE starts a new transaction.
- Requests arriving in ACCESS or DONE are ignored. They are not queued.
- I/O map (decoded from `iAddr[3:2]` within the window; `iAddr[1:0]` ignored):
  - Offset 0x0: switch register, read-only. Value is the 2-flop-synchronised `iSW`, zero-extended to 32 bits. Writes are ignored.
  - Offset 0x4: port register, read/write. A write updates `oPORT` at the IDLE→DONE edge. A read returns the current `oPORT`.
  - Offsets 0x8 and 0xC, and any address whose byte offset from `IO_BASE` is 0x10 or more: reads return 0, writes are ignored. Such accesses still complete with `oRdy`.
- I/O accesses never assert `oMemRead` or `oMemWrite`.

## Timing
- Cycle 0 is the cycle in which the request is sampled in IDLE.
- RAM access:
  - Strobes are high in cycles 1..`WAIT_STATES`+1.
  - `iMemData` is sampled at the end of cycle `WAIT_STATES`+1.
  - `oRdy` is high in cycle `WAIT_STATES`+2.
  - For the default (`WAIT_STATES` = 1), `oRdy` is in cycle 3.
- I/O access: `oRdy` is high in cycle 1. An `oPORT` write is visible from cycle 1.
- Back-to-back transactions: the earliest next request is sampled in the cycle after DONE.
- `iSW` latency: a change on `iSW` is readable from the switch register 2 cycles later.
- Reset (`nRst` low) is immediate and asynchronous, including mid-ACCESS or in DONE. All of the following clear:
  - state → IDLE, counter → 0
  - `oRdy`, `oMemRead`, `oMemWrite` → 0
  - `oData`, `oMemAddr`, `oMemData` → 0
  - `oPORT` → 0, switch synchronisers → 0
- An interrupted transaction is not resumed, and no `oRdy` is issued for it.

## Test plan
- Reset: assert `nRst` = 0 mid-ACCESS → strobes, `oRdy` and `oPORT` all 0 immediately. Release reset → IDLE, and no stray `oRdy` follows.
- RAM write, `WAIT_STATES` = 1:
  - Stimulus: `iWrite` with addr 0x100, data 0xDEADBEEF.
  - Required: `oMemWrite` high in cycles 1–2 with `oMemAddr` = 0x100 and `oMemData` = 0xDEADBEEF; `oRdy` in cycle 3.
- RAM read, `WAIT_STATES` = 3:
  - Stimulus: model MMU returns 0x12345678 for addr 0x100.
  - Required: `oMemRead` high in cycles 1–4; `oRdy` in cycle 5 with `oData` = 0x12345678.
- I/O port:
  - Write 0x0000_00A5 to 0xFFF4 → `oPORT` = 0xA5 and `oRdy` in cycle 1, with no MMU strobe.
  - Read 0xFFF4 → `oData` = 0xA5.
- Switches and unmapped I/O:
  - Set `iSW` = 18'h2ABCD and wait 2 cycles; read 0xFFF0 → `oData` = 0x0002ABCD.
  - Write to 0xFFF0 → ignored.
  - Read 0xFFF8 → 0.
- Request edge cases:
  - `iRead` and `iWrite` high together → a write is performed.
  - Request held high after `oRdy` → a second full transaction starts.
  - Request pulsed during ACCESS → ignored.
